// File: rtl/dig_clk_pkg.sv
// Shared definitions for the dig_clk / dig_countdown family: time field
// widths and limits, the countdown state encoding and hh:mm:ss helpers.
package dig_clk_pkg;

  localparam int SEC_W   = 7;
  localparam int MIN_W   = 7;
  localparam int HR_W    = 5;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } hms_t;

  // True when every field is inside its clock range.
  function automatic logic hms_valid(hms_t t);
    return (t.sec <= SEC_W'(SEC_MAX)) &&
           (t.min <= MIN_W'(MIN_MAX)) &&
           (t.hr  <= HR_W'(HR_MAX));
  endfunction

endpackage

// File: rtl/dig_countdown_if.sv
// Control/status bundle of the dig_countdown timer.
// master: the controller driving load/start/pause; slave: the timer.
interface dig_countdown_if;
  import dig_clk_pkg::*;

  logic             load;
  logic [SEC_W-1:0] ld_sec;
  logic [MIN_W-1:0] ld_min;
  logic [HR_W-1:0]  ld_hr;
  logic             start;
  logic             pause;
  logic [SEC_W-1:0] sec;
  logic [MIN_W-1:0] min;
  logic [HR_W-1:0]  hr;
  logic             busy;
  logic             done;
  logic             expired;
  logic             load_err;

  modport master (
    output load, ld_sec, ld_min, ld_hr, start, pause,
    input  sec, min, hr, busy, done, expired, load_err
  );

  modport slave (
    input  load, ld_sec, ld_min, ld_hr, start, pause,
    output sec, min, hr, busy, done, expired, load_err
  );

endinterface

// File: rtl/dig_countdown_tick_prescaler.sv
// tick_prescaler: divides clk down to one tick every TICKS_PER_SEC enabled
// cycles. The count advances only while en is high; clr restarts it at 0.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Cycle counter: clear has priority, wraps to 0 on the tick cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dig_countdown.sv
// dig_countdown: hh:mm:ss countdown timer, down-counting sibling of dig_clk.
// Optional build macro DIG_COUNTDOWN_AUTO_RELOAD_EN: on expiry reload the
// last accepted load value and keep running (periodic timer).
module dig_countdown
  import dig_clk_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic           clk,
  input  logic           rst,
  dig_countdown_if.slave bus
);

  state_t state;
  hms_t   cur;
  hms_t   ld_val;
  hms_t   dec_val;
  logic   ld_ok;
  logic   cur_zero;
  logic   final_pend;
  logic   tick;
  logic   pre_en;
  logic   pre_clr;
  logic   busy;
  logic   done;
  logic   expired;
  logic   load_err;
`ifdef DIG_COUNTDOWN_AUTO_RELOAD_EN
  hms_t   saved;
`endif

  // Borrow-chain decrement; 00:00:00 stays at zero.
  function automatic hms_t hms_dec(hms_t t);
    hms_t r;
    r = t;
    if (t.sec != '0) begin
      r.sec = t.sec - SEC_W'(1);
    end else if (t.min != '0) begin
      r.min = t.min - MIN_W'(1);
      r.sec = SEC_W'(SEC_MAX);
    end else if (t.hr != '0) begin
      r.hr  = t.hr - HR_W'(1);
      r.min = MIN_W'(MIN_MAX);
      r.sec = SEC_W'(SEC_MAX);
    end
    return r;
  endfunction

  assign ld_val     = {bus.ld_hr, bus.ld_min, bus.ld_sec};
  assign ld_ok      = bus.load && hms_valid(ld_val);
  assign cur_zero   = (cur == '0);
  assign final_pend = (cur.hr == '0) && (cur.min == '0) && (cur.sec == SEC_W'(1));
  assign dec_val    = hms_dec(cur);

  // A pause cycle does not advance the prescaler, so no second is lost;
  // the exception is the last second, where an expiring tick beats pause.
  assign pre_en  = (state == RUN) && !bus.load && (!bus.pause || final_pend);
  assign pre_clr = ld_ok || ((state == IDLE) && !bus.load && bus.start);

  tick_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  // Timer FSM with registered time and status outputs (load > start > pause).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cur      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      expired  <= 1'b0;
      load_err <= 1'b0;
`ifdef DIG_COUNTDOWN_AUTO_RELOAD_EN
      saved    <= '0;
`endif
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (bus.load) begin
        if (ld_ok) begin
          cur     <= ld_val;
          state   <= IDLE;
          busy    <= 1'b0;
          expired <= 1'b0;
`ifdef DIG_COUNTDOWN_AUTO_RELOAD_EN
          saved   <= ld_val;
`endif
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              if (cur_zero) begin
                state   <= DONE;
                done    <= 1'b1;
                expired <= 1'b1;
              end else begin
                state <= RUN;
                busy  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (tick) begin
              if (dec_val == '0) begin
                done <= 1'b1;
`ifdef DIG_COUNTDOWN_AUTO_RELOAD_EN
                if (saved != '0) begin
                  cur <= saved;
                end else begin
                  cur     <= '0;
                  state   <= DONE;
                  busy    <= 1'b0;
                  expired <= 1'b1;
                end
`else
                cur     <= '0;
                state   <= DONE;
                busy    <= 1'b0;
                expired <= 1'b1;
`endif
              end else begin
                cur <= dec_val;
              end
            end else if (bus.pause) begin
              state <= PAUSE;
            end
          end
          PAUSE: begin
            if (bus.start) begin
              state <= RUN;
            end
          end
          DONE: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sec      = cur.sec;
  assign bus.min      = cur.min;
  assign bus.hr       = cur.hr;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.expired  = expired;
  assign bus.load_err = load_err;

endmodule

// File: doc/dig_countdown.md
Name: dig_countdown

Overview:
- Countdown timer: the down-counting counterpart of the team's free-running up-counting dig_clk.
- Loads an hh:mm:ss value, counts it down once per prescaled tick to 00:00:00, then flags expiry.
- Time outputs use the same sec/min/hr widths as dig_clk, so both blocks share display and compare logic.

Parameters:
- TICKS_PER_SEC, 1, clk cycles per one-second decrement (>=1); 1 = decrement every cycle, the same rate as dig_clk.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- load  in  1  capture ld_hr/ld_min/ld_sec this cycle
- ld_sec  in  7  load value, seconds
- ld_min  in  7  load value, minutes
- ld_hr  in  5  load value, hours
- start  in  1  begin/resume countdown
- pause  in  1  hold countdown
- sec  out  7  remaining seconds 0..59
- min  out  7  remaining minutes 0..59
- hr  out  5  remaining hours 0..23
- busy  out  1  high in RUN or PAUSE
- done  out  1  one-cycle pulse on reaching 00:00:00
- expired  out  1  level, high in DONE
- load_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, prescaler 0, saved reload value 0.
- States:
  - IDLE: holding the loaded value.
  - RUN: counting down.
  - PAUSE: frozen.
  - DONE: reached zero.
- Input priority each cycle: load > start > pause.
- load, any state:
  - Accepted if ld_sec<=59, ld_min<=59 and ld_hr<=23.
  - On accept: sec/min/hr take the load value next edge, the value is saved for reload, the prescaler clears, state becomes IDLE, expired clears.
  - Out-of-range: outputs and state unchanged; load_err pulses the next cycle.
- start:
  - In IDLE with a nonzero time: go to RUN, prescaler clears.
  - In IDLE at 00:00:00: go to DONE; done pulses and expired rises on that edge.
  - In PAUSE: resume RUN; the prescaler keeps its count.
  - In RUN or DONE: ignored.
- pause: RUN -> PAUSE; ignored in other states.
- Tick: in RUN, the prescaler counts 0..TICKS_PER_SEC-1. The tick fires in the cycle the count equals TICKS_PER_SEC-1, then the count wraps to 0. With TICKS_PER_SEC=1 the tick fires every RUN cycle. The first decrement happens TICKS_PER_SEC edges after entering RUN.
- Decrement on tick, borrow chain:
  - sec>0: sec-1.
  - else min>0: min-1, sec=59.
  - else hr>0: hr-1, min=59, sec=59.
- Expiry: the decrement that produces 00:00:00 moves to DONE on the same edge. done is high for exactly that one cycle and expired stays high.
- DONE is left only by load or reset.
- A pause asserted in the same cycle as the final tick is ignored: expiry wins, and the state goes to DONE.
- The prescaler holds in IDLE, PAUSE and DONE.
- No wrap below zero, ever.
- Outputs are registered and never exceed 59/59/23.

Optional Feature:
- DIG_COUNTDOWN_AUTO_RELOAD_EN
- Defined: on expiry, done pulses, sec/min/hr reload the saved value on the same edge, and the state stays RUN (periodic timer). expired is never set. If the saved value is 00:00:00, enter DONE as normal.
- Undefined: enter DONE as described above.

Decomposition:
- Package dig_clk_pkg holds:
  - state enum {IDLE, RUN, PAUSE, DONE}
  - constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23
  - width constants SEC_W=7, MIN_W=7, HR_W=5, shared with dig_clk
- Sub-module tick_prescaler (parameter TICKS_PER_SEC; ports clk, rst, en, clr, tick) generates the decrement tick.

Test Plan:
- Load 00:01:02, start, TICKS_PER_SEC=1 -> sequence 00:01:01, 00:01:00, 00:00:59 ... 00:00:00; done pulses once on the 62nd edge after start; expired stays 1; busy falls at the same time.
- Load 01:00:00, start -> the next value is 00:59:59 (full borrow chain).
- Load 00:00:05, start, pause after 2 ticks, hold 10 cycles, start -> value frozen at 00:00:03 during the hold, then expires 3 ticks after resume.
- Load 00:00:00, start -> DONE with a done pulse; load 00:60:00 -> load_err pulses, outputs unchanged.
- Drop rst mid-RUN at 00:00:07 -> outputs go to 0 immediately, without waiting for clk; state IDLE; start after release goes straight to DONE.
- With DIG_COUNTDOWN_AUTO_RELOAD_EN, load 00:00:03, start -> done pulses every 3 ticks, expired stays 0, busy stays 1.
